// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// single-entry holding register with valid/ready handshake and per-frame status.
module uart_rx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  // Elaboration-time guard against unsupported parameter values
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
  end
  if (PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic                 sync1;
  logic                 rxs;
  logic                 rxs_d;
  logic                 armed;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;

  logic fall_c;
  logic half_tick_c;
  logic bit_tick_c;
  logic cnt_clr_c;
  logic start_ok_c;
  logic sample_data_c;
  logic sample_par_c;
  logic sample_stop_c;
  logic commit_c;
  logic par_calc_c;
  logic par_err_c;
  logic frame_err_c;

  // Input synchroniser plus delayed copy for edge detection; idle level is 1
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall_c      = rxs_d & ~rxs;
  assign half_tick_c = (cnt == HALF_LAST);
  assign bit_tick_c  = (cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (armed && fall_c) begin
          state_nx = S_START;
        end
      end
      S_START: begin
        if (half_tick_c) begin
          state_nx = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick_c && (idx == DATA_LAST)) begin
          state_nx = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_tick_c) begin
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick_c && (idx == STOP_LAST)) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-state sampling strobes; the bit counter restarts at every sample point
  always_comb begin
    cnt_clr_c     = 1'b0;
    start_ok_c    = 1'b0;
    sample_data_c = 1'b0;
    sample_par_c  = 1'b0;
    sample_stop_c = 1'b0;
    commit_c      = 1'b0;
    unique case (state)
      S_IDLE: cnt_clr_c = 1'b1;
      S_START: begin
        if (half_tick_c) begin
          cnt_clr_c  = 1'b1;
          start_ok_c = ~rxs;
        end
      end
      S_DATA: begin
        if (bit_tick_c) begin
          cnt_clr_c     = 1'b1;
          sample_data_c = 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_tick_c) begin
          cnt_clr_c    = 1'b1;
          sample_par_c = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick_c) begin
          cnt_clr_c     = 1'b1;
          sample_stop_c = 1'b1;
          commit_c      = (idx == STOP_LAST);
        end
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  // Frame datapath: timing counter, bit index, LSB-first shifter, status capture
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      armed    <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      // Re-arm only after rxs is seen high in IDLE, so a held break cannot retrigger
      if (state == S_IDLE) begin
        armed <= armed | rxs;
      end else begin
        armed <= 1'b0;
      end

      if (cnt_clr_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (start_ok_c || (sample_data_c && (idx == DATA_LAST))) begin
        idx <= '0;
      end else if (sample_data_c || sample_stop_c) begin
        idx <= idx + IDX_W'(1);
      end

      if (sample_data_c) begin
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end

      if (sample_par_c) begin
        par_bit <= rxs;
      end

      if (start_ok_c) begin
        stop_err <= 1'b0;
      end else if (sample_stop_c) begin
        stop_err <= stop_err | ~rxs;
      end
    end
  end

  assign par_calc_c  = ^{shreg, par_bit};
  assign frame_err_c = stop_err | ~rxs;

  always_comb begin
    par_err_c = 1'b0;
    if (PARITY_MODE == 1) begin
      par_err_c = par_calc_c;
    end else if (PARITY_MODE == 2) begin
      par_err_c = ~par_calc_c;
    end
  end

  // Holding register: a commit always wins; an accept alone clears the status
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_nx != S_IDLE);
      if (commit_c) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        parity_err <= par_err_c;
        frame_err  <= frame_err_c;
        overrun    <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a default instance and an even-parity instance.
module tb_uart_rx_param;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_a, rdy_a, rx_b, rdy_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a;
  logic       rx_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .rx(rx_a), .rx_ready(rdy_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
    .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .rx(rx_b), .rx_ready(rdy_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
    .overrun(overrun_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   len_a = 0;
  int   len_b = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bits in transmit order: start, data LSB first, optional parity, stop
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic par_en,
                                           input logic par, input logic stop);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par_en) begin
      f[9]  = par;
      f[10] = stop;
    end else begin
      f[9] = stop;
    end
    return f;
  endfunction

  task automatic send_bits(input int n, input logic [15:0] bits, input bit sel_b);
    for (int i = 0; i < n; i++) begin
      if (sel_b) rx_b = bits[i];
      else       rx_a = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // A frame has been committed when busy drops after a full-length busy period
  always @(negedge clk) begin : mon_a
    if (!n_rst) begin
      len_a = 0;
    end else if (busy_a) begin
      len_a++;
    end else begin
      if (len_a > int'(CPB)) begin
        if (q_a.size() == 0) begin
          check_val("a_unexpected_frame", 32'(rx_data_a), 32'hFFFF_FFFF);
        end else begin
          e_a = q_a.pop_front();
          check_val("a_data", 32'(rx_data_a), 32'(e_a.data));
          check_val("a_flags", 32'({rx_valid_a, parity_err_a, frame_err_a, overrun_a}),
                    32'({1'b1, e_a.perr, e_a.ferr, e_a.ovr}));
        end
      end
      len_a = 0;
    end
  end

  always @(negedge clk) begin : mon_b
    if (!n_rst) begin
      len_b = 0;
    end else if (busy_b) begin
      len_b++;
    end else begin
      if (len_b > int'(CPB)) begin
        if (q_b.size() == 0) begin
          check_val("b_unexpected_frame", 32'(rx_data_b), 32'hFFFF_FFFF);
        end else begin
          e_b = q_b.pop_front();
          check_val("b_data", 32'(rx_data_b), 32'(e_b.data));
          check_val("b_flags", 32'({rx_valid_b, parity_err_b, frame_err_b, overrun_b}),
                    32'({1'b1, e_b.perr, e_b.ferr, e_b.ovr}));
        end
      end
      len_b = 0;
    end
  end

  initial begin
    logic [15:0] fr;
    n_rst = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b1;
    repeat (4) @(negedge clk);
    check_val("reset_a", 32'({rx_data_a, rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a}), 32'(0));
    check_val("reset_b", 32'({rx_data_b, rx_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b}), 32'(0));
    n_rst = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame, held until accepted
    q_a.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_bits(10, mk_frame(8'hA5, 1'b0, 1'b0, 1'b1), 1'b0);
    repeat (5) @(negedge clk);
    check_val("basic_valid_held", 32'(rx_valid_a), 32'(1));
    rdy_a = 1'b1;
    @(negedge clk);
    check_val("basic_accept", 32'({rx_valid_a, parity_err_a, frame_err_a, overrun_a}), 32'(0));
    repeat (10) @(negedge clk);

    // Even parity: correct then wrong parity bit
    q_b.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_bits(11, mk_frame(8'h03, 1'b1, 1'b0, 1'b1), 1'b1);
    q_b.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    send_bits(11, mk_frame(8'h03, 1'b1, 1'b1, 1'b1), 1'b1);
    repeat (10) @(negedge clk);

    // Framing error followed by a 40-bit break, then a clean frame
    q_a.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    send_bits(10, mk_frame(8'h3C, 1'b0, 1'b0, 1'b0), 1'b0);
    repeat (40 * CPB) @(negedge clk);
    check_val("break_idle", 32'({rx_valid_a, busy_a}), 32'(0));
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    q_a.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_bits(10, mk_frame(8'h81, 1'b0, 1'b0, 1'b1), 1'b0);
    repeat (10) @(negedge clk);

    // Glitch: 4-cycle low pulse; busy high for HALF cycles starting at t+1
    rx_a = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check_val($sformatf("glitch_busy_k%0d", k), 32'(busy_a), 32'((k >= 3 && k <= 10) ? 1 : 0));
      if (k == 4) rx_a = 1'b1;
    end
    repeat (40) @(negedge clk);
    check_val("glitch_no_valid", 32'(rx_valid_a), 32'(0));

    // Overrun with consumer stalled
    rdy_a = 1'b0;
    q_a.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_bits(10, mk_frame(8'h11, 1'b0, 1'b0, 1'b1), 1'b0);
    q_a.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    send_bits(10, mk_frame(8'h22, 1'b0, 1'b0, 1'b1), 1'b0);
    repeat (4) @(negedge clk);
    rdy_a = 1'b1;
    @(negedge clk);
    check_val("ovr_accept_clears", 32'({rx_valid_a, overrun_a}), 32'(0));
    rdy_a = 1'b0;
    repeat (10) @(negedge clk);

    // Accept in exactly the second commit cycle (t = start+2, commit = t+HALF+9*CPB)
    q_a.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_bits(10, mk_frame(8'h11, 1'b0, 1'b0, 1'b1), 1'b0);
    q_a.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    fork
      send_bits(10, mk_frame(8'h22, 1'b0, 1'b0, 1'b1), 1'b0);
      begin
        repeat (2 + CPB / 2 + 9 * CPB) @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check_val("same_cycle_held", 32'({rx_data_a, rx_valid_a, overrun_a}), 32'({8'h22, 1'b1, 1'b0}));

    // Reset during data bit 3 with a frame still held
    fr = mk_frame(8'h77, 1'b0, 1'b0, 1'b1);
    send_bits(4, fr, 1'b0);
    rx_a = fr[4];
    repeat (4) @(negedge clk);
    check_val("pre_reset_busy", 32'({busy_a, rx_valid_a}), 32'({1'b1, 1'b1}));
    n_rst = 1'b0;
    rx_a  = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mid_reset_a", 32'({rx_data_a, rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a}), 32'(0));
    n_rst = 1'b1;
    rdy_a = 1'b1;
    repeat (20) @(negedge clk);
    q_a.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_bits(10, mk_frame(8'h5A, 1'b0, 1'b0, 1'b1), 1'b0);
    repeat (20) @(negedge clk);

    check_val("a_sb_drained", 32'(q_a.size()), 32'(0));
    check_val("b_sb_drained", 32'(q_b.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
